// File: rtl/jts16_pkg.sv
// Shared definitions for the System 16 ROM request blocks: request FSM states
// and default SDRAM geometry for the char ROM slot.
`timescale 1ns/1ps
package jts16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } romrq_state_t;

  localparam int SDRAM_AW_DEF = 22;

  // Char ROM sits at the bottom of its SDRAM bank.
  localparam logic [SDRAM_AW_DEF-1:0] CHAR_OFFSET = 22'h0;

endpackage

// File: rtl/jts16_romrq_cache.sv
// One-entry tagged ROM cache: valid/tag/data registers and the hit compare.
// Flush wins over fill, so a download can never leave a stale entry valid.
`timescale 1ns/1ps
module jts16_romrq_cache #(
  parameter int AW = 14,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_fill,
  input  logic [AW-1:0] i_fill_tag,
  input  logic [DW-1:0] i_fill_data,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] o_data,
  output logic          o_hit
);

  logic          r_valid;
  logic [AW-1:0] r_tag;
  logic [DW-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_tag   <= i_fill_tag;
      r_data  <= i_fill_data;
    end
  end

  assign o_data = r_data;
  assign o_hit  = r_valid && (r_tag == i_addr);

endmodule

// File: rtl/jts16_char_romrq.sv
// Char-layer tile ROM responder: one-entry cache in front of a req/ack/rdy
// SDRAM read port. SDRAM handshake: req is held high until a one-cycle ack;
// rdy is a one-cycle pulse qualifying din and is only honoured after ack.
`timescale 1ns/1ps
module jts16_char_romrq
  import jts16_pkg::*;
#(
  parameter int                  AW       = 14,
  parameter int                  DW       = 16,
  parameter int                  SDRAM_AW = SDRAM_AW_DEF,
  parameter logic [SDRAM_AW-1:0] OFFSET   = CHAR_OFFSET,
  parameter int                  TIMEOUT  = 63
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic [AW-1:0]       char_addr,
  output logic [DW-1:0]       char_data,
  output logic                char_ok,
  output logic [SDRAM_AW-1:0] sdram_addr,
  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                sdram_rdy,
  input  logic [DW-1:0]       sdram_din,
  output logic [1:0]          o_dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  romrq_state_t        r_state, w_state_nxt;
  logic                r_req, w_req_nxt;
  logic [AW-1:0]       r_req_addr, w_req_addr_nxt;
  logic [SDRAM_AW-1:0] r_sdram_addr, w_sdram_addr_nxt;
  logic [TW-1:0]       r_timer, w_timer_nxt;
  logic                w_fill;
  logic                w_hit;
  logic [SDRAM_AW-1:0] w_char_sdram;

  jts16_romrq_cache #(
    .AW (AW),
    .DW (DW)
  ) u_cache (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (downloading),
    .i_fill      (w_fill),
    .i_fill_tag  (r_req_addr),
    .i_fill_data (sdram_din),
    .i_addr      (char_addr),
    .o_data      (char_data),
    .o_hit       (w_hit)
  );

  assign char_ok      = w_hit && !downloading;
  assign w_char_sdram = OFFSET + {{(SDRAM_AW-AW){1'b0}}, char_addr};

  always_comb begin
    w_state_nxt      = r_state;
    w_req_nxt        = r_req;
    w_req_addr_nxt   = r_req_addr;
    w_sdram_addr_nxt = r_sdram_addr;
    w_timer_nxt      = r_timer;
    w_fill           = 1'b0;
    if (downloading) begin
      w_state_nxt = ST_IDLE;
      w_req_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!char_ok) begin
            w_req_addr_nxt   = char_addr;
            w_sdram_addr_nxt = w_char_sdram;
            w_req_nxt        = 1'b1;
            w_state_nxt      = ST_REQ;
          end
        end
        ST_REQ: begin
          // Ack freezes the address the controller has just latched.
          if (sdram_ack) begin
            w_req_nxt   = 1'b0;
            w_timer_nxt = '0;
            if (sdram_rdy) begin
              w_fill      = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt = ST_WAIT;
            end
          end else if (char_addr != r_req_addr) begin
            w_req_addr_nxt   = char_addr;
            w_sdram_addr_nxt = w_char_sdram;
          end
        end
        ST_WAIT: begin
          w_timer_nxt = r_timer + 1'b1;
          if (sdram_rdy) begin
            w_fill      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_req        <= 1'b0;
      r_req_addr   <= '0;
      r_sdram_addr <= '0;
      r_timer      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_req        <= w_req_nxt;
      r_req_addr   <= w_req_addr_nxt;
      r_sdram_addr <= w_sdram_addr_nxt;
      r_timer      <= w_timer_nxt;
    end
  end

  assign sdram_req   = r_req;
  assign sdram_addr  = r_sdram_addr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_jts16_char_romrq.sv
// Bench for jts16_char_romrq: directed scenarios plus a random phase, all
// checked every cycle against a transaction-level model of the cache.
`timescale 1ns/1ps
module tb_jts16_char_romrq;

  localparam int                 TIMEOUT = 8;
  localparam logic [21:0]        OFF2    = 22'h3F_FFF0;

  logic        clk = 1'b0;
  logic        rst;
  logic        downloading;
  logic [13:0] char_addr;
  logic [15:0] char_data, char_data2;
  logic        char_ok, char_ok2;
  logic [21:0] sdram_addr, sdram_addr2;
  logic        sdram_req, sdram_req2;
  logic [1:0]  dbg_state, dbg_state2;
  logic        w_ack, w_rdy;
  logic [15:0] w_din;

  logic        resp_en;
  logic        man_ack, man_rdy;
  logic [15:0] man_din;
  logic        rsp_ack, rsp_rdy;
  logic [15:0] rsp_din;
  int          rsp_ph, rsp_cnt;

  int n_checks = 0;
  int n_err    = 0;

  assign w_ack = resp_en ? rsp_ack : man_ack;
  assign w_rdy = resp_en ? rsp_rdy : man_rdy;
  assign w_din = resp_en ? rsp_din : man_din;

  always #5 clk = ~clk;

  jts16_char_romrq #(.OFFSET(22'h0), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .downloading(downloading), .char_addr(char_addr),
    .char_data(char_data), .char_ok(char_ok), .sdram_addr(sdram_addr),
    .sdram_req(sdram_req), .sdram_ack(w_ack), .sdram_rdy(w_rdy),
    .sdram_din(w_din), .o_dbg_state(dbg_state)
  );

  jts16_char_romrq #(.OFFSET(OFF2), .TIMEOUT(TIMEOUT)) dut_off (
    .clk(clk), .rst(rst), .downloading(downloading), .char_addr(char_addr),
    .char_data(char_data2), .char_ok(char_ok2), .sdram_addr(sdram_addr2),
    .sdram_req(sdram_req2), .sdram_ack(w_ack), .sdram_rdy(w_rdy),
    .sdram_din(w_din), .o_dbg_state(dbg_state2)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: one outstanding read, tracked as "presented" then "in flight".
  logic        m_req, m_out, m_valid, m_loaded;
  logic [13:0] m_req_addr, m_tag;
  logic [15:0] m_data;
  int          m_age;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_req = 0; m_out = 0; m_valid = 0; m_loaded = 0;
      m_req_addr = 0; m_tag = 0; m_data = 0; m_age = 0;
    end else if (downloading) begin
      m_req = 0; m_out = 0; m_valid = 0;
    end else if (m_req) begin
      if (w_ack) begin
        m_req = 0;
        if (w_rdy) begin
          m_valid = 1; m_tag = m_req_addr; m_data = w_din;
        end else begin
          m_out = 1; m_age = 0;
        end
      end else begin
        m_req_addr = char_addr;
      end
    end else if (m_out) begin
      m_age++;
      if (w_rdy) begin
        m_out = 0; m_valid = 1; m_tag = m_req_addr; m_data = w_din;
      end else if (m_age == TIMEOUT) begin
        m_out = 0;
      end
    end else if (!(m_valid && m_tag == char_addr)) begin
      m_req = 1; m_req_addr = char_addr; m_loaded = 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic [21:0] e_addr, e_addr2;
      e_addr  = m_loaded ? {8'h0, m_req_addr} : 22'h0;
      e_addr2 = m_loaded ? OFF2 + {8'h0, m_req_addr} : 22'h0;
      check("cyc_ok",    char_ok, m_valid && (m_tag == char_addr) && !downloading);
      check("cyc_data",  char_data, m_data);
      check("cyc_req",   sdram_req, m_req);
      check("cyc_addr",  sdram_addr, e_addr);
      check("cyc_req2",  sdram_req2, m_req);
      check("cyc_addr2", sdram_addr2, e_addr2);
    end
  end

  // Autonomous controller for the random phase: random ack and rdy delays,
  // rdy delays longer than TIMEOUT exercise re-requests.
  initial begin
    rsp_ack = 0; rsp_rdy = 0; rsp_din = 0; rsp_ph = 0; rsp_cnt = 0;
    forever begin
      @(posedge clk); #2;
      rsp_ack = 0; rsp_rdy = 0;
      if (!resp_en) begin
        rsp_ph = 0;
      end else begin
        if (rsp_ph == 0 && sdram_req) begin
          rsp_ph = 1; rsp_cnt = $urandom_range(0, 3);
        end
        if (rsp_ph == 1) begin
          if (!sdram_req) rsp_ph = 0;
          else if (rsp_cnt == 0) begin
            rsp_ack = 1;
            rsp_cnt = $urandom_range(0, 10);
            if (rsp_cnt == 0) begin
              rsp_rdy = 1; rsp_din = 16'($urandom); rsp_ph = 0;
            end else rsp_ph = 2;
          end else rsp_cnt--;
        end else if (rsp_ph == 2) begin
          rsp_cnt--;
          if (rsp_cnt == 0) begin
            rsp_rdy = 1; rsp_din = 16'($urandom); rsp_ph = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic pulse_ack();
    man_ack = 1; tick(); man_ack = 0;
  endtask

  task automatic pulse_rdy(input logic [15:0] d);
    man_din = d; man_rdy = 1; tick(); man_rdy = 0;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!sdram_req && n < 50) begin tick(); n++; end
    check(nm, sdram_req, 1'b1);
  endtask

  task automatic fill(input logic [13:0] a, input logic [15:0] d);
    char_addr = a;
    wait_req("fill_req");
    pulse_ack();
    pulse_rdy(d);
    check("fill_ok", char_ok, 1'b1);
    check("fill_data", char_data, d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; downloading = 0; char_addr = 14'h0123;
    resp_en = 0; man_ack = 0; man_rdy = 0; man_din = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_req", sdram_req, 1'b0);
    check("rst_addr", sdram_addr, 22'h0);
    check("rst_addr2", sdram_addr2, 22'h0);
    check("rst_data", char_data, 16'h0);
    check("rst_ok", char_ok, 1'b0);

    // First miss: request next cycle, ack two cycles in, rdy later.
    rst = 0;
    tick();
    check("s1_req", sdram_req, 1'b1);
    check("s1_addr", sdram_addr, 22'h000123);
    check("s1_addr2", sdram_addr2, 22'h000113);
    tick();
    pulse_ack();
    check("s1_req_drop", sdram_req, 1'b0);
    tick(); tick();
    pulse_rdy(16'hBEEF);
    check("s1_ok", char_ok, 1'b1);
    check("s1_data", char_data, 16'hBEEF);
    repeat (5) tick();
    check("s1_hold_noreq", sdram_req, 1'b0);

    // Hit/miss alternation on a one-entry cache.
    fill(14'h0010, 16'h1111);
    char_addr = 14'h0011; #1;
    check("s2_miss", char_ok, 1'b0);
    char_addr = 14'h0010; #1;
    check("s2_hit", char_ok, 1'b1);
    fill(14'h0011, 16'h2222);
    char_addr = 14'h0010; #1;
    check("s2_evicted", char_ok, 1'b0);
    fill(14'h0010, 16'h3333);

    // Retarget before ack.
    char_addr = 14'h0200;
    wait_req("s3_req");
    check("s3_addr0", sdram_addr, 22'h000200);
    char_addr = 14'h0201;
    tick();
    check("s3_addr1", sdram_addr, 22'h000201);
    pulse_ack();
    pulse_rdy(16'h5555);
    check("s3_ok", char_ok, 1'b1);
    char_addr = 14'h0200; #1;
    check("s3_oldaddr", char_ok, 1'b0);

    // Address change after ack: stale data lands under its own tag.
    char_addr = 14'h0300;
    wait_req("s4_req");
    pulse_ack();
    char_addr = 14'h0301;
    tick();
    pulse_rdy(16'hAAAA);
    check("s4_ok", char_ok, 1'b0);
    check("s4_data", char_data, 16'hAAAA);
    check("s4_noreq", sdram_req, 1'b0);
    char_addr = 14'h0300; #1;
    check("s4_tag", char_ok, 1'b1);
    char_addr = 14'h0301;
    tick();
    check("s4_rereq", sdram_req, 1'b1);
    check("s4_readdr", sdram_addr, 22'h000301);
    pulse_ack();
    pulse_rdy(16'h0301);
    check("s4_ok2", char_ok, 1'b1);

    // Timeout: rdy withheld, req returns 9 cycles after the ack cycle.
    char_addr = 14'h0400;
    wait_req("s5_req");
    pulse_ack();
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k < 9) check("s5_quiet", sdram_req, 1'b0);
    end
    check("s5_rereq", sdram_req, 1'b1);
    check("s5_addr", sdram_addr, 22'h000400);
    pulse_rdy(16'hDEAD);
    check("s5_late_ok", char_ok, 1'b0);
    check("s5_late_req", sdram_req, 1'b1);
    pulse_ack();
    pulse_rdy(16'h4444);
    check("s5_ok", char_ok, 1'b1);
    check("s5_data", char_data, 16'h4444);

    // Download during WAIT discards the in-flight data.
    char_addr = 14'h0500;
    wait_req("s6_req");
    pulse_ack();
    downloading = 1; #1;
    check("s6_ok_dl", char_ok, 1'b0);
    tick();
    check("s6_req_dl", sdram_req, 1'b0);
    pulse_rdy(16'hBAD0);
    tick();
    check("s6_data_kept", char_data, 16'h4444);
    downloading = 0;
    tick();
    check("s6_fresh_req", sdram_req, 1'b1);
    check("s6_fresh_addr", sdram_addr, 22'h000500);
    pulse_ack();
    pulse_rdy(16'h5050);
    check("s6_ok", char_ok, 1'b1);
    downloading = 1; #1;
    check("s6_flush_ok", char_ok, 1'b0);
    tick();
    downloading = 0; #1;
    check("s6_flushed", char_ok, 1'b0);
    tick();
    check("s6_refetch", sdram_req, 1'b1);
    pulse_ack();
    pulse_rdy(16'h5151);

    // OFFSET wrap on the second instance.
    char_addr = 14'h0020;
    wait_req("s7_req");
    check("s7_wrap", sdram_addr2, 22'h000010);
    check("s7_addr", sdram_addr, 22'h000020);
    pulse_ack();
    pulse_rdy(16'h2020);

    // Random phase against the autonomous controller.
    resp_en = 1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 7) == 0) char_addr = 14'h0010 + 14'($urandom_range(0, 3));
      downloading = ($urandom_range(0, 99) < 3);
    end
    downloading = 0;
    repeat (30) tick();
    resp_en = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
